// File: rtl/atanh_x.sv
// Fixed-point inverse hyperbolic tangent, Q5.26 in and out.
// Odd Taylor series up to y^9/9 on the operand magnitude. Inputs beyond
// LIMIT saturate to +/-SAT_VAL. The handshake is wa/comp/en with a locked
// hold-off, shared with the activation units.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for wa==0
// LOAD  | capture operand ox
// ABS   | split the operand into sign and magnitude
// CHECK | choose saturation or the series path
// SQ    | y^2
// P3    | y^3; the accumulator starts at y
// T3    | add y^3/3 and form y^5
// T5    | add y^5/5 and form y^7
// T7    | add y^7/7 and form y^9
// T9    | add y^9/9 to give the magnitude result
// SIGN  | reapply the operand sign
// DONE  | present the result until the consumer takes it (comp)
module atanh_x #(
  parameter logic [31:0] LIMIT   = 32'h0380_0000,
  parameter logic [31:0] SAT_VAL = 32'h0800_0000,
  parameter int          FRAC    = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        locked,
  input  logic [31:0] ox,
  input  logic        wa,
  input  logic        comp,
  output logic [31:0] atanh,
  output logic        en
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_ABS   = 4'd2,
    S_CHECK = 4'd3,
    S_SQ    = 4'd4,
    S_P3    = 4'd5,
    S_T3    = 4'd6,
    S_T5    = 4'd7,
    S_T7    = 4'd8,
    S_T9    = 4'd9,
    S_SIGN  = 4'd10,
    S_DONE  = 4'd11
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [31:0] r_y;
  logic [31:0] r_mag;
  logic [31:0] r_y2;
  logic [31:0] r_p;
  logic [31:0] r_acc;
  logic [31:0] r_res;
  logic        r_neg;
  logic        w_clr;
  logic        w_sat;

  // Unsigned Q5.26 multiply. Every operand is below 1.0, so the
  // truncated product never loses significant bits.
  function automatic logic [31:0] f_qmul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    return 32'(prod >> FRAC);
  endfunction

  assign w_clr = rst | locked;
  assign w_sat = (r_y == 32'h8000_0000) || (r_mag > LIMIT);

  // State register with synchronous clear
  always_ff @(posedge clk) begin
    if (w_clr) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (!wa) w_state_nx = S_LOAD;
      S_LOAD:  w_state_nx = S_ABS;
      S_ABS:   w_state_nx = S_CHECK;
      S_CHECK: w_state_nx = w_sat ? S_SIGN : S_SQ;
      S_SQ:    w_state_nx = S_P3;
      S_P3:    w_state_nx = S_T3;
      S_T3:    w_state_nx = S_T5;
      S_T5:    w_state_nx = S_T7;
      S_T7:    w_state_nx = S_T9;
      S_T9:    w_state_nx = S_SIGN;
      S_SIGN:  w_state_nx = S_DONE;
      S_DONE:  if (comp) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_y   <= '0;
      r_mag <= '0;
      r_y2  <= '0;
      r_p   <= '0;
      r_acc <= '0;
      r_res <= '0;
      r_neg <= 1'b0;
      atanh <= '0;
      en    <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: r_y <= ox;
        S_ABS: begin
          r_neg <= r_y[31];
          r_mag <= r_y[31] ? (-r_y) : r_y;
        end
        S_CHECK: if (w_sat) r_res <= SAT_VAL;
        S_SQ: r_y2 <= f_qmul(r_mag, r_mag);
        S_P3: begin
          r_p   <= f_qmul(r_y2, r_mag);
          r_acc <= r_mag;
        end
        S_T3: begin
          r_acc <= r_acc + (r_p / 32'd3);
          r_p   <= f_qmul(r_p, r_y2);
        end
        S_T5: begin
          r_acc <= r_acc + (r_p / 32'd5);
          r_p   <= f_qmul(r_p, r_y2);
        end
        S_T7: begin
          r_acc <= r_acc + (r_p / 32'd7);
          r_p   <= f_qmul(r_p, r_y2);
        end
        S_T9: r_res <= r_acc + (r_p / 32'd9);
        S_SIGN: r_res <= r_neg ? (-r_res) : r_res;
        S_DONE: begin
          atanh <= r_res;
          en    <= ~comp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atanh_x.sv
// Self-checking bench for atanh_x: directed cases plus randomized operands
// checked against a floating-free arithmetic reference of the series.
module tb_atanh_x;

  logic        clk = 1'b0;
  logic        rst, locked, wa, comp;
  logic [31:0] ox;
  logic [31:0] atanh;
  logic        en;

  int errors = 0;
  int checks = 0;

  atanh_x dut (
    .clk(clk), .rst(rst), .locked(locked), .ox(ox),
    .wa(wa), .comp(comp), .atanh(atanh), .en(en)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] LIM = 32'h0380_0000;
  localparam logic [31:0] SAT = 32'h0800_0000;

  function automatic bit is_sat(input logic [31:0] y);
    longint unsigned m;
    m = y[31] ? ((64'h1_0000_0000 - {32'd0, y}) & 64'hFFFF_FFFF) : {32'd0, y};
    return (m > {32'd0, LIM});
  endfunction

  // atanh(y) ~ sum over odd k of y^k/k, each power truncated to Q26
  function automatic logic [31:0] ref_atanh(input logic [31:0] y);
    longint unsigned m, y2, pw, acc;
    logic [31:0] r;
    m = y[31] ? ((64'h1_0000_0000 - {32'd0, y}) & 64'hFFFF_FFFF) : {32'd0, y};
    if (m > {32'd0, LIM}) begin
      r = SAT;
    end else begin
      y2  = (m * m) >> 26;
      pw  = m;
      acc = 0;
      for (int k = 1; k <= 9; k += 2) begin
        acc = acc + pw / longint'(k);
        pw  = (pw * y2) >> 26;
      end
      r = acc[31:0];
    end
    return y[31] ? (-r) : r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full request: latency, result, hold while comp=0, release on comp=1
  task automatic request(input logic [31:0] v);
    logic [31:0] exp_v;
    int          exp_lat;
    int          lat;
    exp_v   = ref_atanh(v);
    exp_lat = is_sat(v) ? 6 : 12;
    ox = v;
    wa = 1'b0;
    tick();
    lat = 1;
    wa  = 1'b1;
    while (!en && lat < 40) begin
      tick();
      lat++;
      if (lat == 2) ox = ~v;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result", atanh, exp_v);
    repeat (3) tick();
    chk("hold_en", {31'd0, en}, 32'd1);
    chk("hold_val", atanh, exp_v);
    comp = 1'b1;
    tick();
    chk("release_en", {31'd0, en}, 32'd0);
    comp = 1'b0;
  endtask

  logic [31:0] v;
  logic        seen;

  initial begin
    rst = 1'b1; locked = 1'b0; wa = 1'b1; comp = 1'b0; ox = 32'd0;
    repeat (3) tick();
    chk("reset_en", {31'd0, en}, 32'd0);
    chk("reset_val", atanh, 32'd0);
    rst = 1'b0;
    tick();

    // Directed values from hand-derived constants
    request(32'h0200_0000);
    chk("half_const", atanh, 32'h0232_6E85);
    request(32'hFE00_0000);
    chk("neghalf_const", atanh, 32'hFDCD_917B);
    request(32'h0000_0000);
    chk("zero_const", atanh, 32'h0000_0000);
    request(32'h0399_9999);
    chk("sat_pos", atanh, 32'h0800_0000);
    request(32'hFC66_6667);
    chk("sat_neg", atanh, 32'hF800_0000);
    request(32'h8000_0000);
    chk("most_neg", atanh, 32'hF800_0000);
    request(32'h0380_0000);
    chk("limit_below_sat", {31'd0, (atanh < SAT)}, 32'd1);
    request(32'h0380_0001);
    request(32'hFC80_0000);

    // wa held high: nothing starts
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (en) seen = 1'b1;
    end
    chk("wa_high_idle", {31'd0, seen}, 32'd0);

    // rst during T5 abandons the computation
    ox = 32'h0200_0000; wa = 1'b0;
    tick();
    wa = 1'b1;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_en", {31'd0, en}, 32'd0);
    chk("rst_mid_val", atanh, 32'd0);
    request(32'h0200_0000);

    // locked during T3 abandons the computation
    ox = 32'hFE00_0000; wa = 1'b0;
    tick();
    wa = 1'b1;
    repeat (5) tick();
    locked = 1'b1;
    tick();
    locked = 1'b0;
    chk("lock_mid_en", {31'd0, en}, 32'd0);
    chk("lock_mid_val", atanh, 32'd0);
    request(32'hFE00_0000);

    // comp already high on DONE entry: en never rises, result still lands
    comp = 1'b1;
    ox = 32'h0100_0000; wa = 1'b0;
    tick();
    wa = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (en) seen = 1'b1;
    end
    chk("comp_early_en", {31'd0, seen}, 32'd0);
    chk("comp_early_val", atanh, ref_atanh(32'h0100_0000));
    comp = 1'b0;
    tick();
    request(32'h0300_0000);

    // Randomized operands, mostly in series range, some saturating
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        v = $urandom;
      end else begin
        v = $urandom_range(0, 32'h0380_0000);
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      request(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/atanh_x.md
Name: atanh_x

Overview:
- Fixed-point inverse hyperbolic tangent unit; the inverse-direction companion to the tanh activation unit.
- Converts a Q5.26 value y back to atanh(y) via an odd Taylor series up to y^9/9, with saturation near |y| = 1.
- Uses the same wa/comp/en request handshake and the same locked hold-off as the activation units, so the top-level controller drives both identically.

Parameters:
- LIMIT, 32'h0380_0000 (0.875), largest magnitude evaluated by series; |y| > LIMIT saturates.
- SAT_VAL, 32'h0800_0000 (2.0), magnitude returned on saturation.
- FRAC, 26, fractional bits of the Q5.26 format (1 sign, 5 integer, 26 fraction bits).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- locked  input  1  synchronous clear, same effect as rst while high
- ox  input  32  signed Q5.26 operand y, captured in LOAD
- wa  input  1  wait; while high the block stays in IDLE
- comp  input  1  consumer has taken the result; releases DONE
- atanh  output  32  signed Q5.26 result, registered
- en  output  1  result valid, registered

Behaviour:
- Reset: rst or locked high at a clock edge -> state IDLE, en=0, atanh=0, all internal registers 0. This applies mid-computation too; the computation is abandoned.
- Datapath works on the magnitude; sign is reapplied at the end. Products are 64-bit unsigned; the rescaled value is bits [57:26].
  - Because |y| <= 0.875, every power and term is < 1.0, so no overflow occurs.
- Divisions by 3, 5, 7 and 9 are unsigned integer divides of the Q5.26 word, truncating.
- States, one transition per clock:
  - IDLE: if wa==0 -> LOAD, else stay.
  - LOAD: y <= ox.
  - ABS: neg <= y[31]; mag <= y[31] ? -y : y.
  - CHECK: if y==32'h8000_0000 or mag > LIMIT (unsigned compare): res <= SAT_VAL, -> SIGN. Otherwise -> SQ. mag == LIMIT is evaluated by series.
  - SQ: y2 <= mag*mag>>26.
  - P3: p <= y2*mag>>26; acc <= mag.
  - T3: acc <= acc + p/3; p <= p*y2>>26.
  - T5: acc <= acc + p/5; p <= p*y2>>26.
  - T7: acc <= acc + p/7; p <= p*y2>>26.
  - T9: res <= acc + p/9.
  - SIGN: res <= neg ? -res : res.
  - DONE: atanh <= res. If comp==0, en <= 1 and stay; if comp==1, en <= 0 and -> IDLE.
- Latency, counting the edge that samples wa=0 in IDLE as edge 1:
  - Series path: en rises after edge 12.
  - Saturated path: en rises after edge 6.
- atanh is stable whenever en=1 and changes only in DONE or on reset.
- comp already high on DONE entry: en stays 0, block returns to IDLE, atanh still updated. comp must drop before the next result is accepted.
- wa rising mid-computation has no effect; it is sampled only in IDLE.
- ox is sampled only in LOAD; later changes are ignored.
- Back-to-back: after DONE -> IDLE with wa=0, a new LOAD follows on the next edge.

Test Plan:
- Reset mid-computation: rst=1 during T5 -> next edge en=0, atanh=0, state IDLE; a fresh request afterwards gives the correct result.
- ox=32'h0200_0000 (0.5), wa=0, comp=0 -> after 12 edges en=1, atanh=32'h0232_6E85 (0.549250). Result holds until comp=1, then en=0 next edge.
- ox=32'hFE00_0000 (-0.5) -> atanh=32'hFDCD_917B. ox=0 -> atanh=0, en after 12 edges.
- ox=32'h0399_9999 (0.9) -> atanh=32'h0800_0000, en after 6 edges. ox=32'hFC66_6667 (-0.9) -> atanh=32'hF800_0000.
- ox=32'h8000_0000 -> atanh=32'hF800_0000. ox=LIMIT exactly (32'h0380_0000) -> series path, 12-edge latency, result < SAT_VAL.
- Handshake/locked:
  - wa held high 20 cycles -> en stays 0.
  - locked pulsed during T3 -> en=0, atanh=0, restart on wa=0.
  - comp high on DONE entry -> en never asserts, block returns to IDLE.
